io_uart_port: RTL

Memory-mapped serial peripheral that forms the device side of the CPU's I/O window. The CPU's data-RAM stage writes address 64 and the value appears on `IO64_OUT`; this block serializes the low byte of each such write onto a UART TX line. The block also deserializes a UART RX line and returns the received byte plus status on `IO65_IN`, which the CPU reads at address 65. Framing is 8N1, LSB first, with the bit period set by a parameter.

---
 rtl/io_uart_port.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/io_uart_port.sv
`default_nettype none
// ============================================================================
// Module      : io_uart_port
// Description : UART peripheral behind the CPU I/O window. The low byte of each
//               write to address 64 is sent as an 8N1 frame (LSB first) on TXD.
//               Frames arriving on RXD are received and returned, with status
//               bits, on the address-65 read word.
// Ports       : CLK       - clock, rising edge
//               RESET     - synchronous active-high reset
//               IO64_OUT  - CPU output word, [7:0] is the byte to send
//               IO64_WE   - one-cycle strobe: new byte on IO64_OUT
//               IO65_RE   - one-cycle strobe: CPU read of the status word
//               RXD       - asynchronous serial input, idle high
//               TXD       - serial output, idle high
//               IO65_IN   - {TX_BUSY, RX_VALID, RX_OVERRUN, RX_FRAME_ERR,
//                            4'b0, RX_DATA}
// Revision    : 1.0 - initial release
// ============================================================================
module io_uart_port #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] IO64_OUT,
    input  logic        IO64_WE,
    input  logic        IO65_RE,
    input  logic        RXD,
    output logic        TXD,
    output logic [15:0] IO65_IN
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] c_RELOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_HALF    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] c_CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Upper half of the CPU output word carries nothing for this block.
    logic w_unused_hi;
    assign w_unused_hi = ^IO64_OUT[15:8];

    // ------------------------------------------------------------------ TX
    state_t          r_tx_state, w_tx_state;
    logic [CW-1:0]   r_tx_cnt,   w_tx_cnt;
    logic [2:0]      r_tx_bit,   w_tx_bit;
    logic [7:0]      r_tx_shift, w_tx_shift;
    logic            r_txd,      w_txd;
    logic            r_tx_busy,  w_tx_busy;

    always_comb begin
        w_tx_state = r_tx_state;
        w_tx_cnt   = r_tx_cnt;
        w_tx_bit   = r_tx_bit;
        w_tx_shift = r_tx_shift;
        w_txd      = r_txd;
        w_tx_busy  = r_tx_busy;
        case (r_tx_state)
            S_IDLE: begin
                w_txd = 1'b1;
                if (IO64_WE) begin
                    w_tx_shift = IO64_OUT[7:0];
                    w_tx_cnt   = c_RELOAD;
                    w_tx_state = S_START;
                    w_txd      = 1'b0;
                    w_tx_busy  = 1'b1;
                end
            end
            S_START: begin
                if (r_tx_cnt == '0) begin
                    w_tx_cnt   = c_RELOAD;
                    w_tx_bit   = 3'd0;
                    w_tx_state = S_DATA;
                    w_txd      = r_tx_shift[0];
                end else begin
                    w_tx_cnt = r_tx_cnt - c_CNT_ONE;
                end
            end
            S_DATA: begin
                if (r_tx_cnt == '0) begin
                    w_tx_cnt = c_RELOAD;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state = S_STOP;
                        w_txd      = 1'b1;
                    end else begin
                        // Shift so the next bit to send always sits in [0].
                        w_tx_bit   = r_tx_bit + 3'd1;
                        w_tx_shift = {1'b0, r_tx_shift[7:1]};
                        w_txd      = r_tx_shift[1];
                    end
                end else begin
                    w_tx_cnt = r_tx_cnt - c_CNT_ONE;
                end
            end
            S_STOP: begin
                if (r_tx_cnt == '0) begin
                    w_tx_state = S_IDLE;
                    w_tx_busy  = 1'b0;
                    w_txd      = 1'b1;
                end else begin
                    w_tx_cnt = r_tx_cnt - c_CNT_ONE;
                end
            end
            default: w_tx_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'd0;
            r_txd      <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state;
            r_tx_cnt   <= w_tx_cnt;
            r_tx_bit   <= w_tx_bit;
            r_tx_shift <= w_tx_shift;
            r_txd      <= w_txd;
            r_tx_busy  <= w_tx_busy;
        end
    end

    // ------------------------------------------------------------------ RX
    logic            r_rx_meta, r_rx_sync;
    state_t          r_rx_state, w_rx_state;
    logic [CW-1:0]   r_rx_cnt,   w_rx_cnt;
    logic [2:0]      r_rx_bit,   w_rx_bit;
    logic [7:0]      r_rx_shift, w_rx_shift;
    logic [7:0]      r_rx_data,  w_rx_data;
    logic            r_rx_valid, w_rx_valid;
    logic            r_rx_ovr,   w_rx_ovr;
    logic            r_rx_ferr,  w_rx_ferr;

    always_comb begin
        w_rx_state = r_rx_state;
        w_rx_cnt   = r_rx_cnt;
        w_rx_bit   = r_rx_bit;
        w_rx_shift = r_rx_shift;
        w_rx_data  = r_rx_data;
        w_rx_valid = r_rx_valid;
        w_rx_ovr   = r_rx_ovr;
        w_rx_ferr  = r_rx_ferr;
        // Read-clear first; a stop-bit event in the same cycle overrides it.
        if (IO65_RE) begin
            w_rx_valid = 1'b0;
            w_rx_ovr   = 1'b0;
            w_rx_ferr  = 1'b0;
        end
        case (r_rx_state)
            S_IDLE: begin
                if (!r_rx_sync) begin
                    w_rx_cnt   = c_HALF;
                    w_rx_state = S_START;
                end
            end
            S_START: begin
                if (r_rx_cnt == '0) begin
                    if (r_rx_sync) begin
                        w_rx_state = S_IDLE;   // false start, nothing recorded
                    end else begin
                        w_rx_cnt   = c_RELOAD;
                        w_rx_bit   = 3'd0;
                        w_rx_state = S_DATA;
                    end
                end else begin
                    w_rx_cnt = r_rx_cnt - c_CNT_ONE;
                end
            end
            S_DATA: begin
                if (r_rx_cnt == '0) begin
                    w_rx_cnt   = c_RELOAD;
                    w_rx_shift = {r_rx_sync, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state = S_STOP;
                    end else begin
                        w_rx_bit = r_rx_bit + 3'd1;
                    end
                end else begin
                    w_rx_cnt = r_rx_cnt - c_CNT_ONE;
                end
            end
            S_STOP: begin
                if (r_rx_cnt == '0) begin
                    w_rx_state = S_IDLE;
                    if (r_rx_sync) begin
                        w_rx_data  = r_rx_shift;
                        w_rx_valid = 1'b1;
                        // Unread data being overwritten counts as overrun,
                        // unless the CPU is reading it in this very cycle.
                        w_rx_ovr   = w_rx_ovr | (r_rx_valid & ~IO65_RE);
                    end else begin
                        w_rx_ferr  = 1'b1;
                    end
                end else begin
                    w_rx_cnt = r_rx_cnt - c_CNT_ONE;
                end
            end
            default: w_rx_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            // Synchronizer resets to the idle line level so no false start.
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'd0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_rx_ovr   <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_meta  <= RXD;
            r_rx_sync  <= r_rx_meta;
            r_rx_state <= w_rx_state;
            r_rx_cnt   <= w_rx_cnt;
            r_rx_bit   <= w_rx_bit;
            r_rx_shift <= w_rx_shift;
            r_rx_data  <= w_rx_data;
            r_rx_valid <= w_rx_valid;
            r_rx_ovr   <= w_rx_ovr;
            r_rx_ferr  <= w_rx_ferr;
        end
    end

    assign TXD     = r_txd;
    assign IO65_IN = {r_tx_busy, r_rx_valid, r_rx_ovr, r_rx_ferr, 4'b0000, r_rx_data};

endmodule
`default_nettype wire
